u3v_header_gen: RTL

Parametrised U3V stream-header generator. It is the successor to the fixed 32-bit leader builder and emits both the Image / Image Extended Chunk leader and the matching trailer. Output width is 32 or 64 bits, with ready/valid backpressure. All header fields are snapshotted on start. It sits between the frame-control logic and the U3V payload mux, ahead of the GPIF/USB FIFO.

---
 rtl/u3v_header_gen_if.sv | 13 +
 rtl/u3v_header_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/u3v_header_gen_if.sv
// Beat stream carried out of u3v_header_gen: registered valid/data/keep/last plus downstream ready.
interface u3v_header_gen_if #(
    parameter int DATA_WD = 32
);
    logic                  o_valid;
    logic [DATA_WD-1:0]    ov_data;
    logic [DATA_WD/32-1:0] ov_keep;
    logic                  o_last;
    logic                  i_ready;

    modport master (output o_valid, ov_data, ov_keep, o_last, input i_ready);
    modport slave  (input o_valid, ov_data, ov_keep, o_last, output i_ready);
endinterface

// File: rtl/u3v_header_gen.sv
// U3V leader/trailer generator with 32- or 64-bit registered beat output and ready/valid backpressure.
// Trailer path, pending-trailer flag and trailer inputs are built only when U3V_TRAILER_EN is defined.
module u3v_header_gen #(
    parameter int DATA_WD      = 32,
    parameter int SHORT_REG_WD = 16,
    parameter int REG_WD       = 32,
    parameter int LONG_REG_WD  = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_leader_start,
    input  logic                    i_trailer_start,
    input  logic [REG_WD-1:0]       iv_pixel_format,
    input  logic                    i_chunk_mode_active,
    input  logic [LONG_REG_WD-1:0]  iv_blockid,
    input  logic [LONG_REG_WD-1:0]  iv_timestamp,
    input  logic [SHORT_REG_WD-1:0] iv_size_x,
    input  logic [SHORT_REG_WD-1:0] iv_size_y,
    input  logic [SHORT_REG_WD-1:0] iv_offset_x,
    input  logic [SHORT_REG_WD-1:0] iv_offset_y,
    input  logic [LONG_REG_WD-1:0]  iv_valid_payload_size,
    input  logic [15:0]             iv_status,
    input  logic [REG_WD-1:0]       iv_chunk_layout_id,
    u3v_header_gen_if.master        stream,
    output logic                    o_busy,
    output logic                    o_overrun
);

    localparam int KEEP_WD = DATA_WD / 32;

`ifdef U3V_TRAILER_EN
    typedef enum logic [1:0] {IDLE, LEADER, TRAILER} state_t;
`else
    typedef enum logic [1:0] {IDLE, LEADER} state_t;
`endif

    state_t              state;
    logic [3:0]          idx;
    logic [3:0]          total;
    logic                chunk;
    logic [63:0]         blockid;
    logic [63:0]         timestamp;
    logic [31:0]         pixel_format;
    logic [31:0]         size_x;
    logic [31:0]         size_y;
    logic [31:0]         offset_x;
    logic [31:0]         offset_y;
    logic                valid;
    logic [DATA_WD-1:0]  data;
    logic [KEEP_WD-1:0]  keep;
    logic                last;
    logic                busy;
    logic                overrun;
    logic                xfer;
    logic                done;
    logic                load;
    logic                go_leader;
    logic                overrun_nxt;
    logic                busy_nxt;
    logic [31:0]         lo_word;
    logic [DATA_WD-1:0]  beat_data;
    logic [KEEP_WD-1:0]  beat_keep;
    logic                beat_last;
    logic [3:0]          beat_step;
`ifdef U3V_TRAILER_EN
    logic                pending;
    logic                pending_nxt;
    logic                go_trailer;
    logic [31:0]         status;
    logic [63:0]         payload_size;
    logic [31:0]         layout_id;
`else
    logic                unused_trailer_inputs;
    assign unused_trailer_inputs = ^{i_trailer_start, iv_valid_payload_size, iv_status, iv_chunk_layout_id};
`endif

    // Header word i of the active header, built from the snapshot; indices past the end read as zero.
    function automatic logic [31:0] word_at(input logic [3:0] i);
        logic [31:0] w;
        w = 32'h0;
        if (state == LEADER) begin
            case (i)
                4'd0:    w = 32'h4C563355;
                4'd1:    w = {16'd52, 16'h0};
                4'd2:    w = blockid[31:0];
                4'd3:    w = blockid[63:32];
                4'd4:    w = {1'b0, chunk, 14'h0001, 16'h0};
                4'd5:    w = timestamp[31:0];
                4'd6:    w = timestamp[63:32];
                4'd7:    w = pixel_format;
                4'd8:    w = size_x;
                4'd9:    w = size_y;
                4'd10:   w = offset_x;
                4'd11:   w = offset_y;
                default: w = 32'h0;
            endcase
        end
`ifdef U3V_TRAILER_EN
        else if (state == TRAILER) begin
            case (i)
                4'd0:    w = 32'h54563355;
                4'd1:    w = {(chunk ? 16'd36 : 16'd32), 16'h0};
                4'd2:    w = blockid[31:0];
                4'd3:    w = blockid[63:32];
                4'd4:    w = status;
                4'd5:    w = payload_size[31:0];
                4'd6:    w = payload_size[63:32];
                4'd7:    w = size_y;
                4'd8:    w = chunk ? layout_id : 32'h0;
                default: w = 32'h0;
            endcase
        end
`endif
        return w;
    endfunction

    always_comb begin
        total = 4'd0;
        if (state == LEADER) total = 4'd13;
`ifdef U3V_TRAILER_EN
        else if (state == TRAILER) total = chunk ? 4'd9 : 4'd8;
`endif
        lo_word = word_at(idx);
    end

    generate
        if (DATA_WD == 64) begin : g_wide
            logic [31:0] hi_word;
            always_comb begin
                hi_word   = word_at(idx + 4'd1);
                beat_data = {hi_word, lo_word};
                beat_keep = {((idx + 4'd1) < total), 1'b1};
                beat_last = (idx + 4'd2) >= total;
                beat_step = 4'd2;
            end
        end else begin : g_narrow
            always_comb begin
                beat_data = lo_word;
                beat_keep = 1'b1;
                beat_last = (idx + 4'd1) == total;
                beat_step = 4'd1;
            end
        end
    endgenerate

    // A pending trailer takes priority in IDLE; a leader request arriving then is dropped.
    always_comb begin
        xfer = valid && stream.i_ready;
        done = xfer && last;
        load = (state != IDLE) && (idx < total) && (!valid || stream.i_ready);
`ifdef U3V_TRAILER_EN
        go_trailer  = (state == IDLE) && (pending || (i_trailer_start && !i_leader_start));
        go_leader   = (state == IDLE) && !pending && i_leader_start;
        pending_nxt = pending;
        if (go_trailer) pending_nxt = 1'b0;
        if (i_trailer_start && !pending && !go_trailer) pending_nxt = 1'b1;
        overrun_nxt = (i_leader_start && !go_leader) || (i_trailer_start && pending);
        busy_nxt    = go_leader || go_trailer || ((state != IDLE) && !done) || pending_nxt;
`else
        go_leader   = (state == IDLE) && i_leader_start;
        overrun_nxt = i_leader_start && !go_leader;
        busy_nxt    = go_leader || ((state != IDLE) && !done);
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            idx          <= 4'd0;
            chunk        <= 1'b0;
            blockid      <= 64'h0;
            timestamp    <= 64'h0;
            pixel_format <= 32'h0;
            size_x       <= 32'h0;
            size_y       <= 32'h0;
            offset_x     <= 32'h0;
            offset_y     <= 32'h0;
            valid        <= 1'b0;
            data         <= '0;
            keep         <= '0;
            last         <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
`ifdef U3V_TRAILER_EN
            pending      <= 1'b0;
            status       <= 32'h0;
            payload_size <= 64'h0;
            layout_id    <= 32'h0;
`endif
        end else begin
            busy    <= busy_nxt;
            overrun <= overrun_nxt;
`ifdef U3V_TRAILER_EN
            pending <= pending_nxt;
`endif
            if (xfer) valid <= 1'b0;
            if (load) begin
                valid <= 1'b1;
                data  <= beat_data;
                keep  <= beat_keep;
                last  <= beat_last;
                idx   <= idx + beat_step;
            end
            if (done) state <= IDLE;
            if (go_leader) begin
                state        <= LEADER;
                idx          <= 4'd0;
                chunk        <= i_chunk_mode_active;
                blockid      <= 64'(iv_blockid);
                timestamp    <= 64'(iv_timestamp);
                pixel_format <= 32'(iv_pixel_format);
                size_x       <= 32'(iv_size_x);
                size_y       <= 32'(iv_size_y);
                offset_x     <= 32'(iv_offset_x);
                offset_y     <= 32'(iv_offset_y);
            end
`ifdef U3V_TRAILER_EN
            if (go_trailer) begin
                state        <= TRAILER;
                idx          <= 4'd0;
                chunk        <= i_chunk_mode_active;
                blockid      <= 64'(iv_blockid);
                size_y       <= 32'(iv_size_y);
                status       <= 32'(iv_status);
                payload_size <= 64'(iv_valid_payload_size);
                layout_id    <= 32'(iv_chunk_layout_id);
            end
`endif
        end
    end

    assign stream.o_valid = valid;
    assign stream.ov_data = data;
    assign stream.ov_keep = keep;
    assign stream.o_last  = last;
    assign o_busy         = busy;
    assign o_overrun      = overrun;

endmodule
